// File: rtl/tx_pkg.sv
// Shared router definitions for the output-port stage: flit layout, packet length
// and the two-phase link handshake convention.
package tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitAck,
    StDone
  } tx_state_e;

  // Head flag lives in the flit MSB.
  function automatic int unsigned head_bit(input int unsigned size);
    return size - 1;
  endfunction

  function automatic int unsigned flits(input int unsigned buff_bits);
    return 32'd1 << buff_bits;
  endfunction

  // Two-phase link: a flit is accepted once ack has caught up with req.
  function automatic logic hs_accepted(input logic req, input logic ack);
    return req == ack;
  endfunction

endpackage

// File: rtl/tx_if.sv
// Switch grant, input-buffer read port and outgoing two-phase link of the tx stage.
interface tx_if #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned BUFF_BITS = 3
);
  logic                 send;
  logic                 done;
  logic [BUFF_BITS-1:0] buf_addr;
  logic [SIZE-1:0]      buf_data;
  logic                 ch_req;
  logic [SIZE-1:0]      ch_flit;
  logic                 ch_ack;

  modport master (
    input  send, buf_data, ch_ack,
    output done, buf_addr, ch_req, ch_flit
  );

  modport slave (
    output send, buf_data, ch_ack,
    input  done, buf_addr, ch_req, ch_flit
  );
endinterface

// File: rtl/tx.sv
// Router output-port stage: reads a granted packet flit by flit, serialises it over a
// two-phase req/ack link and answers the switch grant with a four-phase done.
module tx
  import tx_pkg::*;
#(
  parameter int          ID        = 0,
  parameter              MOD_NAME  = "TX",
  parameter int unsigned SIZE      = 8,
  parameter int unsigned BUFF_BITS = 3
) (
  input logic  i_clk,
  input logic  i_reset,
  tx_if.master io_bus
);

  localparam logic [BUFF_BITS-1:0] LastIdx = BUFF_BITS'(flits(BUFF_BITS) - 1);

  if (SIZE < 2 || BUFF_BITS < 1) begin : g_param_check
    $error("%s%0d: SIZE must hold a head bit plus payload, BUFF_BITS must be >= 1",
           MOD_NAME, ID);
  end

  tx_state_e            r_state, w_state;
  logic                 r_done, w_done;
  logic                 r_req, w_req;
  logic [SIZE-1:0]      r_flit, w_flit;
  // One register serves as both flit counter and buffer address.
  logic [BUFF_BITS-1:0] r_cnt, w_cnt;
  logic                 w_acked;

  assign w_acked = hs_accepted(r_req, io_bus.ch_ack);

  always_comb begin
    w_state = r_state;
    w_done  = r_done;
    w_req   = r_req;
    w_flit  = r_flit;
    w_cnt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (io_bus.send) begin
          w_cnt   = '0;
          w_state = StLoad;
        end
      end
      StLoad: begin
        // buf_data is sampled only here; the link holds this copy until acked.
        w_flit  = io_bus.buf_data;
        w_req   = ~r_req;
        w_state = StWaitAck;
      end
      StWaitAck: begin
        if (w_acked) begin
          if (r_cnt == LastIdx) begin
            w_done  = 1'b1;
            w_state = StDone;
          end else begin
            w_cnt   = r_cnt + BUFF_BITS'(1);
            w_state = StLoad;
          end
        end
      end
      StDone: begin
        if (!io_bus.send) begin
          w_done  = 1'b0;
          w_state = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_flit  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_done  <= w_done;
      r_req   <= w_req;
      r_flit  <= w_flit;
      r_cnt   <= w_cnt;
    end
  end

  assign io_bus.done     = r_done;
  assign io_bus.ch_req   = r_req;
  assign io_bus.ch_flit  = r_flit;
  assign io_bus.buf_addr = r_cnt;

endmodule

// File: tb/tb_tx.sv
// Directed bench for tx: buffer model, ack mirror with per-flit delay, toggle monitor.
module tb_tx;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [7:0] mem[8];
  logic [7:0] exp_pkt[8];
  int         dly[8];
  int         wcnt;

  logic [7:0] got_flit[$];
  logic [2:0] got_addr[$];
  logic       prev_req;

  tx_if #(.SIZE(8), .BUFF_BITS(3)) bus ();

  tx #(.ID(0), .MOD_NAME("TX"), .SIZE(8), .BUFF_BITS(3)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.buf_data = mem[bus.buf_addr];

  // Downstream partner: registered ack, shares reset, optional extra wait per flit.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.ch_ack <= 1'b0;
      wcnt       <= 0;
    end else if (bus.ch_req !== bus.ch_ack) begin
      if (wcnt >= dly[bus.buf_addr]) begin
        bus.ch_ack <= bus.ch_req;
        wcnt       <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.ch_req !== prev_req) begin
      got_flit.push_back(bus.ch_flit);
      got_addr.push_back(bus.buf_addr);
    end
    prev_req = bus.ch_req;
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.send = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.ch_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", bus.ch_req); end
    tests++; if (bus.ch_flit !== 8'h00) begin fails++; $display("FAIL reset_flit got %h want 00", bus.ch_flit); end
    tests++; if (bus.buf_addr !== 3'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", bus.buf_addr); end
    got_flit.delete(); got_addr.delete();
    repeat (5) @(negedge clk);
    tests++; if (got_flit.size() != 0) begin fails++; $display("FAIL reset_idle_toggles got %0d want 0", got_flit.size()); end
  endtask

  task automatic test_basic();
    logic r0;
    bit   ok;
    got_flit.delete(); got_addr.delete();
    bus.send = 1'b1;
    r0 = bus.ch_req;
    @(negedge clk);
    tests++; if (bus.ch_req !== r0) begin fails++; $display("FAIL basic_no_early_toggle got %b want %b", bus.ch_req, r0); end
    @(negedge clk);
    tests++; if (bus.ch_req !== ~r0 || bus.ch_flit !== 8'h85) begin
      fails++; $display("FAIL basic_first_toggle req %b flit %h want req %b flit 85", bus.ch_req, bus.ch_flit, ~r0);
    end
    wait_done(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_done_timeout done %b want 1", bus.done); end
    tests++; if (got_flit.size() != 8) begin fails++; $display("FAIL basic_count got %0d want 8", got_flit.size()); end
    for (int i = 0; i < 8 && i < got_flit.size(); i++) begin
      tests++;
      if (got_flit[i] !== exp_pkt[i] || got_addr[i] !== 3'(i)) begin
        fails++; $display("FAIL basic_flit%0d got %h@%0d want %h@%0d", i, got_flit[i], got_addr[i], exp_pkt[i], i);
      end
    end
    repeat (3) @(negedge clk);
    tests++; if (bus.done !== 1'b1 || got_flit.size() != 8) begin
      fails++; $display("FAIL basic_done_hold done %b toggles %0d want 1 and 8", bus.done, got_flit.size());
    end
    bus.send = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL basic_done_drop got %b want 0", bus.done); end
  endtask

  task automatic test_ack_delay();
    bit   ok;
    logic rq;
    dly[3] = 10;
    got_flit.delete(); got_addr.delete();
    bus.send = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.buf_addr === 3'd3 && bus.ch_req !== bus.ch_ack) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL delay_reach_flit3 addr %0d want 3", bus.buf_addr); end
    rq = bus.ch_req;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (bus.ch_flit !== 8'h03 || bus.buf_addr !== 3'd3 || bus.ch_req !== rq) begin
        fails++; $display("FAIL delay_hold cyc%0d flit %h addr %0d req %b want 03 3 %b", i, bus.ch_flit, bus.buf_addr, bus.ch_req, rq);
      end
      @(negedge clk);
    end
    wait_done(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL delay_done_timeout done %b want 1", bus.done); end
    tests++; if (got_flit.size() != 8 || got_flit[3] !== 8'h03 || got_flit[7] !== 8'h07) begin
      fails++; $display("FAIL delay_packet count %0d want 8 with flit3=03 flit7=07", got_flit.size());
    end
    bus.send = 1'b0;
    dly[3]   = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_send_drop();
    bit ok;
    int dc;
    got_flit.delete(); got_addr.delete();
    bus.send = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (got_flit.size() >= 1) break;
    end
    bus.send = 1'b0;
    wait_done(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL drop_done_timeout done %b want 1", bus.done); end
    dc = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dc++;
    end
    tests++; if (dc != 1) begin fails++; $display("FAIL drop_done_width got %0d cycles want 1", dc); end
    repeat (5) @(negedge clk);
    tests++; if (got_flit.size() != 8) begin fails++; $display("FAIL drop_count got %0d want 8", got_flit.size()); end
    for (int i = 0; i < 8 && i < got_flit.size(); i++) begin
      tests++;
      if (got_flit[i] !== exp_pkt[i]) begin
        fails++; $display("FAIL drop_flit%0d got %h want %h", i, got_flit[i], exp_pkt[i]);
      end
    end
  endtask

  task automatic test_last_withheld();
    bit ok;
    dly[7] = 50;
    bus.send = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.buf_addr === 3'd7 && bus.ch_req !== bus.ch_ack) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL withheld_reach_flit7 addr %0d want 7", bus.buf_addr); end
    ok = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tests++;
      if (bus.done !== 1'b0) begin fails++; $display("FAIL withheld_early_done cyc%0d got %b want 0", i, bus.done); end
      if (bus.ch_ack === bus.ch_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!ok) begin fails++; $display("FAIL withheld_ack_timeout ack %b req %b", bus.ch_ack, bus.ch_req); end
    @(negedge clk);
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL withheld_done_rise got %b want 1", bus.done); end
    bus.send = 1'b0;
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL withheld_done_fall got %b want 0", bus.done); end
    dly[7] = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    dly[4] = 20;
    bus.send = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.buf_addr === 3'd4 && bus.ch_req !== bus.ch_ack) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL midrst_reach_flit4 addr %0d want 4", bus.buf_addr); end
    repeat (3) @(negedge clk);
    rst_n    = 1'b0;
    bus.send = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done got %b want 0", bus.done); end
    tests++; if (bus.ch_req !== 1'b0) begin fails++; $display("FAIL midrst_req got %b want 0", bus.ch_req); end
    tests++; if (bus.ch_flit !== 8'h00) begin fails++; $display("FAIL midrst_flit got %h want 00", bus.ch_flit); end
    tests++; if (bus.buf_addr !== 3'd0) begin fails++; $display("FAIL midrst_addr got %0d want 0", bus.buf_addr); end
    dly[4] = 0;
    rst_n  = 1'b1;
    @(negedge clk);
    got_flit.delete(); got_addr.delete();
    bus.send = 1'b1;
    wait_done(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL midrst_done_timeout done %b want 1", bus.done); end
    tests++; if (got_flit.size() != 8) begin fails++; $display("FAIL midrst_count got %0d want 8", got_flit.size()); end
    for (int i = 0; i < 8 && i < got_flit.size(); i++) begin
      tests++;
      if (got_flit[i] !== exp_pkt[i] || got_addr[i] !== 3'(i)) begin
        fails++; $display("FAIL midrst_flit%0d got %h@%0d want %h@%0d", i, got_flit[i], got_addr[i], exp_pkt[i], i);
      end
    end
    bus.send = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    prev_req = 1'b0;
    rst_n    = 1'b0;
    bus.send = 1'b0;
    exp_pkt  = '{8'h85, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    for (int i = 0; i < 8; i++) begin
      mem[i] = exp_pkt[i];
      dly[i] = 0;
    end
    test_reset();
    test_basic();
    test_ack_delay();
    test_send_drop();
    test_last_withheld();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
